// File: rtl/rv_store_unit.sv
// RV32 store unit: turns one SB/SH/SW into one or two word-aligned, byte-enabled
// bus writes, splitting misaligned accesses that cross a word boundary.
module rv_store_unit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        st_valid,
   output logic        st_ready,
   input  logic [31:0] st_addr,
   input  logic [31:0] st_data,
   input  logic [2:0]  st_funct3,
   output logic        st_done,
   output logic        st_err,
   output logic        bus_req,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_be,
   input  logic        bus_ack,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {IDLE, WR0, WR1, FIN} state_e;

   // Handshakes: a store is taken on a rising edge where st_valid & st_ready;
   // a bus write is complete on a rising edge where bus_req & bus_ack.
   state_e      state_q, state_d;
   logic        bus_req_q, bus_req_d;
   logic [31:0] bus_addr_q, bus_addr_d;
   logic [31:0] bus_wdata_q, bus_wdata_d;
   logic [3:0]  bus_be_q, bus_be_d;
   logic [3:0]  hi_be_q, hi_be_d;
   logic [31:0] hi_data_q, hi_data_d;
   logic        st_done_q, st_done_d;
   logic        st_err_q, st_err_d;

   logic [1:0]  off;
   logic [3:0]  mask4;
   logic [31:0] mask32;
   logic        f3_ok;
   logic [7:0]  be8;
   logic [63:0] d64;

   always_comb begin
      off    = st_addr[1:0];
      mask4  = 4'b0000;
      mask32 = 32'h0;
      f3_ok  = 1'b1;
      case (st_funct3)
         3'b000:  begin mask4 = 4'b0001; mask32 = 32'h0000_00ff; end
         3'b001:  begin mask4 = 4'b0011; mask32 = 32'h0000_ffff; end
         3'b010:  begin mask4 = 4'b1111; mask32 = 32'hffff_ffff; end
         default: f3_ok = 1'b0;
      endcase
      be8 = {4'b0000, mask4} << off;
      d64 = {32'h0, st_data & mask32} << {off, 3'b000};
   end

   // FIN also accepts, so a new store can be taken in the st_done/st_err cycle.
   assign st_ready  = (state_q == IDLE) || (state_q == FIN);
   assign st_done   = st_done_q;
   assign st_err    = st_err_q;
   assign bus_req   = bus_req_q;
   assign bus_addr  = bus_addr_q;
   assign bus_wdata = bus_wdata_q;
   assign bus_be    = bus_be_q;
   assign dbg_state = state_q;

   always_comb begin
      state_d     = state_q;
      bus_req_d   = bus_req_q;
      bus_addr_d  = bus_addr_q;
      bus_wdata_d = bus_wdata_q;
      bus_be_d    = bus_be_q;
      hi_be_d     = hi_be_q;
      hi_data_d   = hi_data_q;
      st_done_d   = 1'b0;
      st_err_d    = 1'b0;
      case (state_q)
         IDLE, FIN: begin
            state_d = IDLE;
            if (st_valid) begin
               if (f3_ok) begin
                  state_d     = WR0;
                  bus_req_d   = 1'b1;
                  bus_addr_d  = {st_addr[31:2], 2'b00};
                  bus_be_d    = be8[3:0];
                  bus_wdata_d = d64[31:0];
                  hi_be_d     = be8[7:4];
                  hi_data_d   = d64[63:32];
               end else begin
                  state_d   = FIN;
                  st_done_d = 1'b1;
                  st_err_d  = 1'b1;
               end
            end
         end
         WR0: begin
            if (bus_ack) begin
               if (hi_be_q != 4'b0000) begin
                  state_d     = WR1;
                  bus_addr_d  = bus_addr_q + 32'd4;
                  bus_be_d    = hi_be_q;
                  bus_wdata_d = hi_data_q;
               end else begin
                  state_d     = IDLE;
                  bus_req_d   = 1'b0;
                  bus_addr_d  = 32'h0;
                  bus_be_d    = 4'b0000;
                  bus_wdata_d = 32'h0;
                  st_done_d   = 1'b1;
               end
            end
         end
         WR1: begin
            if (bus_ack) begin
               state_d     = IDLE;
               bus_req_d   = 1'b0;
               bus_addr_d  = 32'h0;
               bus_be_d    = 4'b0000;
               bus_wdata_d = 32'h0;
               st_done_d   = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         bus_req_q   <= 1'b0;
         bus_addr_q  <= 32'h0;
         bus_wdata_q <= 32'h0;
         bus_be_q    <= 4'b0000;
         hi_be_q     <= 4'b0000;
         hi_data_q   <= 32'h0;
         st_done_q   <= 1'b0;
         st_err_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         bus_req_q   <= bus_req_d;
         bus_addr_q  <= bus_addr_d;
         bus_wdata_q <= bus_wdata_d;
         bus_be_q    <= bus_be_d;
         hi_be_q     <= hi_be_d;
         hi_data_q   <= hi_data_d;
         st_done_q   <= st_done_d;
         st_err_q    <= st_err_d;
      end
   end

endmodule

// File: tb/tb_rv_store_unit.sv
// Bench for rv_store_unit: directed and random stores checked against a byte-level
// model of which bytes land in which bus word.
module tb_rv_store_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        st_valid = 1'b0;
   logic        st_ready;
   logic [31:0] st_addr = 32'h0;
   logic [31:0] st_data = 32'h0;
   logic [2:0]  st_funct3 = 3'b000;
   logic        st_done;
   logic        st_err;
   logic        bus_req;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [3:0]  bus_be;
   logic        bus_ack = 1'b0;
   logic [1:0]  dbg_state;

   int checks = 0;
   int errors = 0;

   logic [31:0] exp_addr_q[$];
   logic [31:0] exp_data_q[$];
   logic [3:0]  exp_be_q[$];
   logic [31:0] obs_addr_q[$];
   logic [31:0] obs_data_q[$];
   logic [3:0]  obs_be_q[$];
   int obs_lat, obs_wait;
   bit obs_done, obs_err, obs_unstable, obs_gap, obs_timeout, obs_idle_ok, obs_err_alone;

   rv_store_unit dut (
      .clk(clk), .rst_n(rst_n), .st_valid(st_valid), .st_ready(st_ready),
      .st_addr(st_addr), .st_data(st_data), .st_funct3(st_funct3),
      .st_done(st_done), .st_err(st_err), .bus_req(bus_req), .bus_addr(bus_addr),
      .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_ack(bus_ack), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Byte i of the store goes to byte address addr+i (mod 2^32); bytes sharing a
   // word address form one bus write, in ascending address order.
   function automatic void model(input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] data);
      int n, nw;
      logic [31:0] a, wa;
      logic [31:0] wad[2];
      logic [31:0] wd[2];
      logic [3:0]  wb[2];
      exp_addr_q.delete(); exp_data_q.delete(); exp_be_q.delete();
      n  = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : (f3 == 3'd2) ? 4 : 0;
      nw = 0;
      for (int i = 0; i < n; i++) begin
         a  = addr + 32'(i);
         wa = a & 32'hFFFF_FFFC;
         if (nw == 0 || wad[nw-1] != wa) begin
            wad[nw] = wa; wb[nw] = 4'b0000; wd[nw] = 32'h0; nw++;
         end
         wb[nw-1][a[1:0]] = 1'b1;
         wd[nw-1][8*a[1:0] +: 8] = data[8*i +: 8];
      end
      for (int j = 0; j < nw; j++) begin
         exp_addr_q.push_back(wad[j]); exp_be_q.push_back(wb[j]); exp_data_q.push_back(wd[j]);
      end
   endfunction

   // Issues one store at a falling edge and acts as the bus slave, acking each
   // request dly cycles after it appears. Records what the bus and core saw.
   task automatic drive_store(input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] data, input int dly);
      int waited;
      bit in_req, had_ack;
      logic [31:0] h_addr, h_data;
      logic [3:0]  h_be;
      obs_addr_q.delete(); obs_data_q.delete(); obs_be_q.delete();
      obs_done = 0; obs_err = 0; obs_unstable = 0; obs_gap = 0; obs_timeout = 0;
      obs_idle_ok = 0; obs_err_alone = 0; obs_lat = 0;
      waited = 0;
      while (!st_ready && waited < 100) begin
         @(posedge clk); @(negedge clk); waited++;
      end
      obs_wait = waited;
      st_valid = 1'b1; st_funct3 = f3; st_addr = addr; st_data = data;
      @(posedge clk); @(negedge clk);
      st_valid = 1'b0; st_addr = $urandom; st_data = $urandom;
      st_funct3 = 3'($urandom_range(0, 7));
      in_req = 0; had_ack = 0; waited = 0;
      h_addr = 32'h0; h_data = 32'h0; h_be = 4'b0000;
      for (int k = 0; k < 200; k++) begin
         bus_ack = 1'b0;
         if (st_err && !st_done) obs_err_alone = 1;
         if (st_done) begin
            obs_done = 1; obs_err = st_err; obs_lat = k + 1;
            obs_idle_ok = !bus_req && bus_addr == 32'h0 && bus_be == 4'b0000 && bus_wdata == 32'h0;
            break;
         end
         if (bus_req) begin
            if (!in_req) begin
               h_addr = bus_addr; h_data = bus_wdata; h_be = bus_be; in_req = 1; waited = 0;
            end else if (bus_addr !== h_addr || bus_wdata !== h_data || bus_be !== h_be) begin
               obs_unstable = 1;
            end
            if (waited >= dly) begin
               bus_ack = 1'b1; in_req = 0; had_ack = 1;
               obs_addr_q.push_back(h_addr); obs_data_q.push_back(h_data); obs_be_q.push_back(h_be);
            end
            waited++;
         end else begin
            if (had_ack) obs_gap = 1;
            bus_ack = 1'($urandom_range(0, 1));
         end
         @(posedge clk); @(negedge clk);
      end
      bus_ack = 1'b0;
      if (!obs_done) obs_timeout = 1;
   endtask

   task automatic test_store(input string name, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] data, input int dly);
      int exp_lat;
      model(f3, addr, data);
      exp_lat = exp_addr_q.size() * (dly + 1) + 1;
      drive_store(f3, addr, data, dly);
      checks++;
      if (obs_timeout) begin
         errors++; $display("FAIL %s done: no st_done within budget", name);
      end
      checks++;
      if (obs_err !== (f3 > 3'd2)) begin
         errors++; $display("FAIL %s err: got %0b expected %0b", name, obs_err, f3 > 3'd2);
      end
      checks++;
      if (!obs_timeout && obs_lat != exp_lat) begin
         errors++; $display("FAIL %s latency: got %0d expected %0d", name, obs_lat, exp_lat);
      end
      checks++;
      if (obs_addr_q.size() != exp_addr_q.size()) begin
         errors++;
         $display("FAIL %s nwrites: got %0d expected %0d", name, obs_addr_q.size(), exp_addr_q.size());
      end
      for (int i = 0; i < obs_addr_q.size() && i < exp_addr_q.size(); i++) begin
         checks++;
         if (obs_addr_q[i] !== exp_addr_q[i] || obs_be_q[i] !== exp_be_q[i] ||
             obs_data_q[i] !== exp_data_q[i]) begin
            errors++;
            $display("FAIL %s write%0d: got addr=%h be=%b wdata=%h expected addr=%h be=%b wdata=%h",
                     name, i, obs_addr_q[i], obs_be_q[i], obs_data_q[i],
                     exp_addr_q[i], exp_be_q[i], exp_data_q[i]);
         end
      end
      checks++;
      if (obs_unstable || obs_gap || obs_err_alone) begin
         errors++;
         $display("FAIL %s protocol: got unstable=%0b gap=%0b err_alone=%0b expected all 0",
                  name, obs_unstable, obs_gap, obs_err_alone);
      end
      checks++;
      if (!obs_timeout && !obs_idle_ok) begin
         errors++; $display("FAIL %s idle_bus: got req=%b addr=%h be=%b wdata=%h expected zeros",
                            name, bus_req, bus_addr, bus_be, bus_wdata);
      end
   endtask

   task automatic test_reset();
      checks++;
      if (st_ready !== 1'b1 || bus_req !== 1'b0 || st_done !== 1'b0 || st_err !== 1'b0) begin
         errors++; $display("FAIL reset ctrl: got ready=%b req=%b done=%b err=%b expected 1000",
                            st_ready, bus_req, st_done, st_err);
      end
      checks++;
      if (bus_addr !== 32'h0 || bus_wdata !== 32'h0 || bus_be !== 4'b0000) begin
         errors++; $display("FAIL reset bus: got addr=%h wdata=%h be=%b expected zeros",
                            bus_addr, bus_wdata, bus_be);
      end
   endtask

   task automatic test_sb();
      test_store("sb", 3'b000, 32'h0000_1003, 32'hAABB_CC5A, 0);
      checks++;
      if (obs_addr_q.size() != 1 || obs_addr_q[0] !== 32'h1000 || obs_be_q[0] !== 4'b1000 ||
          obs_data_q[0] !== 32'h5A00_0000 || obs_lat != 2) begin
         errors++; $display("FAIL sb_const: got %0d writes lat=%0d expected 1000/1000/5a000000 lat 2",
                            obs_addr_q.size(), obs_lat);
      end
   endtask

   task automatic test_sh_stall();
      test_store("sh_stall", 3'b001, 32'h0000_2002, 32'h1234_ABCD, 3);
      @(negedge clk);
      checks++;
      if (st_done !== 1'b0 || st_err !== 1'b0) begin
         errors++; $display("FAIL sh_pulse: got done=%b err=%b expected 0 0", st_done, st_err);
      end
   endtask

   task automatic test_split();
      test_store("sw_split", 3'b010, 32'h0000_3001, 32'h1122_3344, 0);
      checks++;
      if (obs_addr_q.size() != 2 || obs_addr_q[1] !== 32'h3004 || obs_be_q[1] !== 4'b0001 ||
          obs_data_q[1] !== 32'h0000_0011) begin
         errors++; $display("FAIL split_const: got %0d writes expected second 3004/0001/00000011",
                            obs_addr_q.size());
      end
      test_store("sw_split_slow", 3'b010, 32'h0000_3002, 32'hCAFE_F00D, 2);
   endtask

   task automatic test_wrap();
      test_store("sh_wrap", 3'b001, 32'hFFFF_FFFF, 32'h0000_BEEF, 1);
      checks++;
      if (obs_addr_q.size() != 2 || obs_addr_q[0] !== 32'hFFFF_FFFC || obs_data_q[0] !== 32'hEF00_0000 ||
          obs_addr_q[1] !== 32'h0 || obs_data_q[1] !== 32'h0000_00BE) begin
         errors++; $display("FAIL wrap_const: got %0d writes expected fffffffc then 00000000",
                            obs_addr_q.size());
      end
   endtask

   task automatic test_back_to_back();
      test_store("invalid", 3'b011, 32'h0000_5000, 32'h1234_5678, 0);
      test_store("b2b_sw", 3'b010, 32'h0000_4000, 32'hDEAD_BEEF, 0);
      checks++;
      if (obs_wait != 0) begin
         errors++; $display("FAIL b2b_accept: got %0d wait cycles expected 0", obs_wait);
      end
   endtask

   task automatic test_reset_mid_split();
      bit saw_done;
      st_valid = 1'b1; st_funct3 = 3'b010; st_addr = 32'h0000_3001; st_data = 32'h1122_3344;
      @(posedge clk); @(negedge clk);
      st_valid = 1'b0;
      bus_ack = 1'b1;
      @(posedge clk); @(negedge clk);
      bus_ack = 1'b0;
      checks++;
      if (bus_req !== 1'b1 || bus_addr !== 32'h3004) begin
         errors++; $display("FAIL rst_pre: got req=%b addr=%h expected 1 00003004", bus_req, bus_addr);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (bus_req !== 1'b0 || st_done !== 1'b0 || st_ready !== 1'b1 || bus_be !== 4'b0000) begin
         errors++; $display("FAIL rst_async: got req=%b done=%b ready=%b be=%b expected 0 0 1 0000",
                            bus_req, st_done, st_ready, bus_be);
      end
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      saw_done = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (st_done) saw_done = 1;
      end
      checks++;
      if (saw_done || st_ready !== 1'b1) begin
         errors++; $display("FAIL rst_after: got done_seen=%b ready=%b expected 0 1", saw_done, st_ready);
      end
      test_store("post_rst_sb", 3'b000, 32'h0000_6001, 32'h0000_0077, 0);
   endtask

   task automatic test_random();
      logic [2:0]  f3;
      logic [31:0] addr;
      int r;
      for (int n = 0; n < 60; n++) begin
         r = $urandom_range(0, 9);
         f3 = (r < 3) ? 3'd0 : (r < 6) ? 3'd1 : (r < 9) ? 3'd2 : 3'($urandom_range(3, 7));
         addr = $urandom;
         if ($urandom_range(0, 7) == 0) addr = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
         test_store("random", f3, addr, $urandom, $urandom_range(0, 3));
         for (int g = $urandom_range(0, 2); g > 0; g--) @(negedge clk);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      test_reset();
      rst_n = 1'b1;
      @(negedge clk);
      test_sb();
      test_sh_stall();
      test_split();
      test_wrap();
      test_back_to_back();
      test_reset_mid_split();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
